// File: rtl/fetch_if.sv
// Fetch unit bus bundle: program-memory port, execute handshake, ALU flags and status.
`timescale 1ns/1ps

interface fetch_if;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INSN_W = 16;

    logic [ADDR_W-1:0] pm_addr;
    logic              pm_req;
    logic              pm_ack;
    logic [INSN_W-1:0] pm_data;
    logic [INSN_W-1:0] k;
    logic              k_valid;
    logic              k_ready;
    logic              cl;
    logic              zl;
    logic              cf;
    logic              zf;
    logic              halted;
    logic              stk_err;

    // Fetch unit side
    modport master (
        output pm_addr, pm_req, k, k_valid, cf, zf, halted, stk_err,
        input  pm_ack, pm_data, k_ready, cl, zl
    );

    // Memory / ALU side
    modport slave (
        input  pm_addr, pm_req, k, k_valid, cf, zf, halted, stk_err,
        output pm_ack, pm_data, k_ready, cl, zl
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / sequencing unit: fetches words from program memory,
// hands ALU-class instructions to the execute stage, resolves jumps,
// calls/returns and halts locally, and keeps the carry/zero flags.
// Optional feature: define CALL_STACK_EN to enable the 4-entry return stack
// (CALL/RET on opcode 0xC); without it 0xC is a NOP and stk_err is tied low.
`timescale 1ns/1ps

module fetch_unit (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam int unsigned PC_W      = 8;
    localparam int unsigned INSN_W    = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned STK_DEPTH = 4;
    localparam int unsigned STK_IDX_W = 2;
    localparam int unsigned DEPTH_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSN_W-1:0]   ir_q, ir_d;
    logic                cf_q, cf_d;
    logic                zf_q, zf_d;
    logic                pm_req_q, pm_req_d;
    logic                k_valid_q, k_valid_d;
    logic                halted_q, halted_d;

    logic [OP_W-1:0]     opcode;
    logic [PC_W-1:0]     pc_inc;
    logic                jump_taken;

`ifdef CALL_STACK_EN
    logic [PC_W-1:0]      stk_q [STK_DEPTH];
    logic [PC_W-1:0]      stk_d [STK_DEPTH];
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [STK_IDX_W-1:0] top_idx;
    logic                 stk_err_q, stk_err_d;
`endif

    // Instructions the execute stage consumes through the k handshake
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA: is_alu_op = 1'b1;
            default:                                             is_alu_op = 1'b0;
        endcase
    endfunction

    assign opcode = ir_q[15:12];
    assign pc_inc = pc_q + PC_W'(1);

`ifdef CALL_STACK_EN
    assign top_idx = STK_IDX_W'(depth_q - DEPTH_W'(1));
`endif

    // Jump condition select from k[9:8] against the registered flags
    always_comb begin
        jump_taken = 1'b0;
        case (ir_q[9:8])
            2'b00:   jump_taken = 1'b1;
            2'b01:   jump_taken = zf_q;
            2'b10:   jump_taken = cf_q;
            default: jump_taken = ~zf_q;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
`ifdef CALL_STACK_EN
        stk_d     = stk_q;
        depth_d   = depth_q;
        stk_err_d = stk_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (bus.pm_ack) begin
                    ir_d    = bus.pm_data;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA: begin
                        if (bus.k_ready) begin
                            pc_d    = pc_inc;
                            state_d = S_FETCH;
                            if (opcode != 4'hA) begin
                                cf_d = bus.cl;
                                zf_d = bus.zl;
                            end
                        end
                    end

                    4'hB: begin
                        pc_d    = jump_taken ? ir_q[7:0] : pc_inc;
                        state_d = S_FETCH;
                    end

                    4'hC: begin
`ifdef CALL_STACK_EN
                        if (!ir_q[8]) begin
                            // CALL: overflow halts with PC and stack untouched
                            if (depth_q == DEPTH_W'(STK_DEPTH)) begin
                                stk_err_d = 1'b1;
                                state_d   = S_HALT;
                            end else begin
                                stk_d[depth_q[STK_IDX_W-1:0]] = pc_inc;
                                depth_d = depth_q + DEPTH_W'(1);
                                pc_d    = ir_q[7:0];
                                state_d = S_FETCH;
                            end
                        end else begin
                            // RET: underflow halts with PC and stack untouched
                            if (depth_q == '0) begin
                                stk_err_d = 1'b1;
                                state_d   = S_HALT;
                            end else begin
                                pc_d    = stk_q[top_idx];
                                depth_d = depth_q - DEPTH_W'(1);
                                state_d = S_FETCH;
                            end
                        end
`else
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
`endif
                    end

                    4'hF: begin
                        state_d = S_HALT;
                    end

                    default: begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered strobes follow the state being entered
        pm_req_d  = (state_d == S_FETCH);
        k_valid_d = (state_d == S_EXEC) && is_alu_op(ir_d[15:12]);
        halted_d  = (state_d == S_HALT);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, instruction, flags and output strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            cf_q      <= 1'b0;
            zf_q      <= 1'b0;
            pm_req_q  <= 1'b0;
            k_valid_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cf_q      <= cf_d;
            zf_q      <= zf_d;
            pm_req_q  <= pm_req_d;
            k_valid_q <= k_valid_d;
            halted_q  <= halted_d;
        end
    end

`ifdef CALL_STACK_EN
    // Return stack storage, depth and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_q     <= '{default: '0};
            depth_q   <= '0;
            stk_err_q <= 1'b0;
        end else begin
            stk_q     <= stk_d;
            depth_q   <= depth_d;
            stk_err_q <= stk_err_d;
        end
    end

    assign bus.stk_err = stk_err_q;
`else
    assign bus.stk_err = 1'b0;
`endif

    assign bus.pm_addr = pc_q;
    assign bus.pm_req  = pm_req_q;
    assign bus.k       = ir_q;
    assign bus.k_valid = k_valid_q;
    assign bus.cf      = cf_q;
    assign bus.zf      = zf_q;
    assign bus.halted  = halted_q;

endmodule
